// File: rtl/switch_arb_pkg.sv
// Shared types and helpers for the per-output wormhole arbiter.
package switch_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // Widest input count the index helper can decode.
  localparam int ARB_MAX_N = 32;

  // A single "no input selected" bit, replicated to the mux_sel width at use.
  localparam logic ARB_SEL_NONE = 1'b0;

  function automatic int onehot_to_idx(input logic [ARB_MAX_N-1:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < ARB_MAX_N; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set bit of req_i above rr_ptr_i, wrapping.
module rr_priority_picker #(
  parameter int N_INPUTS = 2,
  parameter int IDX_W    = $clog2(N_INPUTS)
) (
  input  logic [N_INPUTS-1:0] req_i,
  input  logic [IDX_W-1:0]    rr_ptr_i,
  output logic [N_INPUTS-1:0] winner_oh_o,
  output logic [IDX_W-1:0]    winner_idx_o
);

  always_comb begin
    int  idx;
    logic found;
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    winner_oh_o  = '0;
    winner_idx_o = '0;
    found        = 1'b0;
    idx          = 0;
    for (int k = 1; k <= N_INPUTS; k++) begin
      idx = (int'(rr_ptr_i) + k) % N_INPUTS;
      if (!found && req_i[idx]) begin
        found            = 1'b1;
        winner_oh_o[idx] = 1'b1;
        winner_idx_o     = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/switch_output_arbiter.sv
// Per-output wormhole arbiter: round-robin grant held from head to tail flit.
// Optional stall watchdog enabled by defining SWITCH_ARB_TIMEOUT_EN.
module switch_output_arbiter
  import switch_arb_pkg::*;
#(
  parameter int N_INPUTS       = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_INPUTS-1:0] req,
  input  logic [N_INPUTS-1:0] flit_valid,
  input  logic [N_INPUTS-1:0] flit_tail,
  input  logic                out_ready,
  output logic [N_INPUTS-1:0] mux_sel,
  output logic [N_INPUTS-1:0] in_pop,
  output logic                out_valid,
  output logic                timeout_err
);

  localparam int IDX_W = $clog2(N_INPUTS);

  arb_state_t           state_q;
  logic [N_INPUTS-1:0]  mux_sel_q;
  logic [IDX_W-1:0]     rr_ptr_q;
  logic [IDX_W-1:0]     grant_idx_q;
  logic [N_INPUTS-1:0]  win_oh;
  logic [IDX_W-1:0]     win_idx;
  logic                 xfer;
  logic                 xfer_tail;

  rr_priority_picker #(
    .N_INPUTS (N_INPUTS)
  ) u_picker (
    .req_i        (req),
    .rr_ptr_i     (rr_ptr_q),
    .winner_oh_o  (win_oh),
    .winner_idx_o (win_idx)
  );

  // mux_sel_q is zero in IDLE, so these gates also force idle outputs to zero.
  assign xfer      = (|(mux_sel_q & flit_valid)) & out_ready;
  assign xfer_tail = (|(mux_sel_q & flit_valid & flit_tail)) & out_ready;
  assign in_pop    = mux_sel_q & flit_valid & {N_INPUTS{out_ready}};
  assign out_valid = |(mux_sel_q & flit_valid);
  assign mux_sel   = mux_sel_q;

`ifdef SWITCH_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] stall_cnt_q;
  logic             timeout_err_q;
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      mux_sel_q   <= {N_INPUTS{ARB_SEL_NONE}};
      rr_ptr_q    <= IDX_W'(N_INPUTS - 1);
      grant_idx_q <= '0;
`ifdef SWITCH_ARB_TIMEOUT_EN
      stall_cnt_q   <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
`ifdef SWITCH_ARB_TIMEOUT_EN
      timeout_err_q <= 1'b0;
`endif
      unique case (state_q)
        ARB_IDLE: begin
          if (|req) begin
            mux_sel_q   <= win_oh;
            grant_idx_q <= win_idx;
            state_q     <= ARB_LOCKED;
`ifdef SWITCH_ARB_TIMEOUT_EN
            stall_cnt_q <= '0;
`endif
          end
        end
        ARB_LOCKED: begin
          if (xfer_tail) begin
            mux_sel_q <= {N_INPUTS{ARB_SEL_NONE}};
            rr_ptr_q  <= grant_idx_q;
            state_q   <= ARB_IDLE;
          end
`ifdef SWITCH_ARB_TIMEOUT_EN
          else if (xfer) begin
            stall_cnt_q <= '0;
          end else if (stall_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            // This stall cycle reaches the limit: force the grant off.
            mux_sel_q     <= {N_INPUTS{ARB_SEL_NONE}};
            rr_ptr_q      <= grant_idx_q;
            state_q       <= ARB_IDLE;
            timeout_err_q <= 1'b1;
            stall_cnt_q   <= '0;
          end else if (stall_cnt_q != CNT_W'(TIMEOUT_CYCLES)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
          end
`endif
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assert property (@(posedge clock) disable iff (reset) $onehot0(mux_sel_q));

  assert property (@(posedge clock) disable iff (reset)
    (state_q == ARB_LOCKED) |->
      ((mux_sel_q != '0) &&
       (onehot_to_idx(ARB_MAX_N'(mux_sel_q)) == int'(grant_idx_q))));

  assert property (@(posedge clock)
    (N_INPUTS >= 2) && (N_INPUTS <= ARB_MAX_N) && (TIMEOUT_CYCLES > 0));

endmodule

// File: tb/tb_switch_output_arbiter.sv
// Bench for switch_output_arbiter: directed scenarios plus random traffic on N=2 and N=4 instances.
module tb_switch_output_arbiter;

  localparam int TO = 8;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] a_req, a_fv, a_tl, a_sel, a_pop;
  logic       a_rdy, a_ov, a_terr;
  logic [3:0] b_req, b_fv, b_tl, b_sel, b_pop;
  logic       b_rdy, b_ov, b_terr;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  switch_output_arbiter #(.N_INPUTS(2), .TIMEOUT_CYCLES(TO)) u_dut2 (
    .clock(clock), .reset(reset), .req(a_req), .flit_valid(a_fv), .flit_tail(a_tl),
    .out_ready(a_rdy), .mux_sel(a_sel), .in_pop(a_pop), .out_valid(a_ov), .timeout_err(a_terr)
  );

  switch_output_arbiter #(.N_INPUTS(4), .TIMEOUT_CYCLES(TO)) u_dut4 (
    .clock(clock), .reset(reset), .req(b_req), .flit_valid(b_fv), .flit_tail(b_tl),
    .out_ready(b_rdy), .mux_sel(b_sel), .in_pop(b_pop), .out_valid(b_ov), .timeout_err(b_terr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: who owns the output (-1 = nobody), who finished last, stall run length.
  int m_n[2] = '{2, 4};
  int m_owner[2];
  int m_last[2];
  int m_stall[2];
  bit m_terr[2];

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_owner[k] = -1;
      m_last[k]  = m_n[k] - 1;
      m_stall[k] = 0;
      m_terr[k]  = 1'b0;
    end
  endfunction

  function automatic void model_update(int k, logic [3:0] rq, logic [3:0] fv,
                                       logic [3:0] tl, logic rdy);
    int g;
    bit found;
    g = m_owner[k];
    found = 1'b0;
    m_terr[k] = 1'b0;
    if (g < 0) begin
      for (int s = 1; s <= m_n[k]; s++) begin
        int c;
        c = (m_last[k] + s) % m_n[k];
        if (!found && rq[c]) begin
          found      = 1'b1;
          m_owner[k] = c;
          m_stall[k] = 0;
        end
      end
    end else if (fv[g] && rdy) begin
      m_stall[k] = 0;
      if (tl[g]) begin
        m_last[k]  = g;
        m_owner[k] = -1;
      end
    end else begin
`ifdef SWITCH_ARB_TIMEOUT_EN
      m_stall[k]++;
      if (m_stall[k] >= TO) begin
        m_last[k]  = g;
        m_owner[k] = -1;
        m_stall[k] = 0;
        m_terr[k]  = 1'b1;
      end
`endif
    end
  endfunction

  function automatic logic [31:0] exp_sel(int k);
    return (m_owner[k] < 0) ? 32'd0 : (32'd1 << m_owner[k]);
  endfunction

  function automatic logic [31:0] exp_pop(int k, logic [3:0] fv, logic rdy);
    int g;
    g = m_owner[k];
    return (g >= 0 && fv[g] && rdy) ? (32'd1 << g) : 32'd0;
  endfunction

  function automatic logic [31:0] exp_ov(int k, logic [3:0] fv);
    int g;
    g = m_owner[k];
    return (g >= 0 && fv[g]) ? 32'd1 : 32'd0;
  endfunction

  task automatic check_outputs();
    check("n2_sel",   32'(a_sel),  exp_sel(0));
    check("n2_pop",   32'(a_pop),  exp_pop(0, {2'b00, a_fv}, a_rdy));
    check("n2_valid", 32'(a_ov),   exp_ov(0, {2'b00, a_fv}));
    check("n2_terr",  32'(a_terr), 32'(m_terr[0]));
    check("n4_sel",   32'(b_sel),  exp_sel(1));
    check("n4_pop",   32'(b_pop),  exp_pop(1, b_fv, b_rdy));
    check("n4_valid", 32'(b_ov),   exp_ov(1, b_fv));
    check("n4_terr",  32'(b_terr), 32'(m_terr[1]));
  endtask

  // Called at posedge+1; inputs stay put until it returns at the next posedge+1.
  task automatic step();
    #4;
    check_outputs();
    @(posedge clock);
    #1;
    model_update(0, {2'b00, a_req}, {2'b00, a_fv}, {2'b00, a_tl}, a_rdy);
    model_update(1, b_req, b_fv, b_tl, b_rdy);
  endtask

  task automatic idle_inputs();
    a_req = '0; a_fv = '0; a_tl = '0; a_rdy = 1'b1;
    b_req = '0; b_fv = '0; b_tl = '0; b_rdy = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] seq [6];
    int pops;
    int cnt;

    reset = 1'b1;
    idle_inputs();
    a_fv = 2'b11;
    model_reset();
    #3;
    check("rst_sel",   32'(a_sel),  32'd0);
    check("rst_pop",   32'(a_pop),  32'd0);
    check("rst_valid", 32'(a_ov),   32'd0);
    check("rst_terr",  32'(a_terr), 32'd0);
    check("rst_sel4",  32'(b_sel),  32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Grant input 1, then reset asynchronously in the middle of the packet.
    a_req = 2'b10; a_fv = 2'b11; a_tl = 2'b00;
    step();
    check("lock_sel", 32'(a_sel), 32'h2);
    reset = 1'b1;
    #1;
    check("midrst_sel",   32'(a_sel), 32'd0);
    check("midrst_valid", 32'(a_ov),  32'd0);
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
    a_req = 2'b11; a_fv = 2'b00;
    step();
    check("postrst_sel", 32'(a_sel), 32'h1);

    // Single-flit packets on both inputs alternate with one bubble each.
    do_reset();
    a_req = 2'b11; a_fv = 2'b11; a_tl = 2'b11;
    seq = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
    for (int i = 0; i < 6; i++) begin
      check("alt_sel", 32'(a_sel), 32'(seq[i]));
      check("alt_pop", 32'(a_pop), 32'(seq[i]));
      step();
    end

    // 4-flit packet on input 0 with backpressure; input 1 requests mid-packet.
    do_reset();
    a_req = 2'b01; a_fv = 2'b01; a_tl = 2'b00;
    step();
    pops = 0;
    for (int cyc = 1; cyc <= 20 && pops < 4; cyc++) begin
      a_rdy = !(cyc == 2 || cyc == 3);
      if (cyc == 2) begin
        a_req = 2'b11; a_fv = 2'b11; a_tl[1] = 1'b1;
      end
      a_tl[0] = (pops == 3);
      #1;
      check("pkt_sel", 32'(a_sel), 32'h1);
      if (!a_rdy) check("pkt_stall_pop", 32'(a_pop), 32'd0);
      if (a_pop[0]) pops++;
      step();
    end
    check("pkt_pops",    32'(pops),  32'd4);
    check("pkt_release", 32'(a_sel), 32'd0);
    step();
    check("nopreempt_grant", 32'(a_sel), 32'h2);
    a_req = 2'b00;
    step();

    // Grant with no flits offered: watchdog release or indefinite hold.
    do_reset();
    a_req = 2'b01; a_fv = 2'b00;
    step();
    check("to_grant", 32'(a_sel), 32'h1);
    a_req = 2'b00;
    cnt = 0;
    while (a_sel != 2'b00 && cnt < 120) begin
      step();
      cnt++;
    end
`ifdef SWITCH_ARB_TIMEOUT_EN
    check("to_cycles", 32'(cnt),    32'd8);
    check("to_err",    32'(a_terr), 32'd1);
    check("to_sel",    32'(a_sel),  32'd0);
    step();
    check("to_err_pulse", 32'(a_terr), 32'd0);
`else
    check("hold_cycles", 32'(cnt),   32'd120);
    check("hold_sel",    32'(a_sel), 32'h1);
    a_fv = 2'b01; a_tl = 2'b01;
    step();
    check("hold_release", 32'(a_sel), 32'd0);
`endif

    // N=4: finish a packet on input 1, then req=1010 picks 3, then 1.
    do_reset();
    b_req = 4'b0010; b_fv = 4'b0010; b_tl = 4'b0010;
    step();
    step();
    b_req = 4'b1010; b_fv = 4'b0000; b_tl = 4'b0000;
    step();
    check("n4_first", 32'(b_sel), 32'h8);
    b_fv = 4'b1010; b_tl = 4'b1010;
    step();
    check("n4_bubble", 32'(b_sel), 32'd0);
    step();
    check("n4_second", 32'(b_sel), 32'h2);

    // Random traffic on both instances against the reference.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      a_req = 2'($urandom);
      a_fv  = 2'($urandom);
      a_tl  = {($urandom_range(2) == 0), ($urandom_range(2) == 0)};
      a_rdy = ($urandom_range(3) != 0);
      b_req = 4'($urandom) & 4'($urandom);
      b_fv  = 4'($urandom);
      b_tl  = 4'($urandom) & 4'($urandom);
      b_rdy = ($urandom_range(3) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
